// File: rtl/bus_demux_pkg.sv
// Shared encodings and defaults for the initiator-to-memory/MMIO request demux.
package bus_demux_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_WAIT = 2'd2
  } bus_state_t;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;
  localparam logic [31:0] ERR_DATA_DEF  = 32'hDEAD_BEEF;

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_IO  = 1'b1;

  localparam int unsigned BE_W = 4;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Watchdog counter for the response wait; saturates at TIMEOUT-1 and flags expiry.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/bus_demux.sv
// 1:2 load/store demux: port 0 = data memory, port 1 = MMIO, one transaction in flight,
// with a watchdog that completes a stuck transaction as an error.
module bus_demux
  import bus_demux_pkg::*;
#(
  parameter int unsigned     DW        = 32,
  parameter int unsigned     AW        = 32,
  parameter logic [AW-1:0]   MMIO_BASE = AW'(MMIO_BASE_DEF),
  parameter int unsigned     TIMEOUT   = 256,
  parameter logic [DW-1:0]   ERR_DATA  = DW'(ERR_DATA_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic            req_we,
  input  logic [BE_W-1:0] req_be,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            t0_req_valid,
  input  logic            t0_req_ready,
  output logic [AW-1:0]   t0_addr,
  output logic            t0_we,
  output logic [BE_W-1:0] t0_be,
  output logic [DW-1:0]   t0_wdata,
  input  logic            t0_rsp_valid,
  input  logic [DW-1:0]   t0_rsp_rdata,
  output logic            t1_req_valid,
  input  logic            t1_req_ready,
  output logic [AW-1:0]   t1_addr,
  output logic            t1_we,
  output logic [BE_W-1:0] t1_be,
  output logic [DW-1:0]   t1_wdata,
  input  logic            t1_rsp_valid,
  input  logic [DW-1:0]   t1_rsp_rdata,
  output logic            err_spurious
);

  bus_state_t      state;
  logic            sel;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [BE_W-1:0] be_q;
  logic [DW-1:0]   wdata_q;

  logic            is_io_c;
  logic            sel_req_ready;
  logic            sel_rsp_valid;
  logic [DW-1:0]   sel_rsp_rdata;
  logic            spurious_c;
  logic            cnt_clr;
  logic            cnt_en;
  logic            expired;

  assign is_io_c       = (req_addr >= MMIO_BASE);
  assign sel_req_ready = (sel == PORT_IO) ? t1_req_ready : t0_req_ready;
  assign sel_rsp_valid = (sel == PORT_IO) ? t1_rsp_valid : t0_rsp_valid;
  assign sel_rsp_rdata = (sel == PORT_IO) ? t1_rsp_rdata : t0_rsp_rdata;

  // A response is legal only from the selected port while waiting for it.
  assign spurious_c = (t0_rsp_valid && !((state == BUS_WAIT) && (sel == PORT_MEM))) ||
                      (t1_rsp_valid && !((state == BUS_WAIT) && (sel == PORT_IO)));

  assign cnt_clr = (state == BUS_REQ) && sel_req_ready;
  assign cnt_en  = (state == BUS_WAIT) && !sel_rsp_valid;

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  // Both target ports see the latched request; only the selected one gets valid.
  assign t0_addr  = addr_q;
  assign t0_we    = we_q;
  assign t0_be    = be_q;
  assign t0_wdata = wdata_q;
  assign t1_addr  = addr_q;
  assign t1_we    = we_q;
  assign t1_be    = be_q;
  assign t1_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BUS_IDLE;
      sel          <= PORT_MEM;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      t0_req_valid <= 1'b0;
      t1_req_valid <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (spurious_c) begin
        err_spurious <= 1'b1;
      end
      case (state)
        BUS_IDLE: begin
          if (req_valid) begin
            addr_q       <= req_addr;
            we_q         <= req_we;
            be_q         <= req_be;
            wdata_q      <= req_wdata;
            sel          <= is_io_c;
            t0_req_valid <= !is_io_c;
            t1_req_valid <= is_io_c;
            req_ready    <= 1'b0;
            state        <= BUS_REQ;
          end
        end
        BUS_REQ: begin
          if (sel_req_ready) begin
            t0_req_valid <= 1'b0;
            t1_req_valid <= 1'b0;
            state        <= BUS_WAIT;
          end
        end
        BUS_WAIT: begin
          // Real response takes priority over a coincident watchdog expiry.
          if (sel_rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= we_q ? '0 : sel_rsp_rdata;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= BUS_IDLE;
          end else if (expired) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= ERR_DATA;
            rsp_err   <= 1'b1;
            req_ready <= 1'b1;
            state     <= BUS_IDLE;
          end
        end
        default: begin
          t0_req_valid <= 1'b0;
          t1_req_valid <= 1'b0;
          req_ready    <= 1'b1;
          state        <= BUS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_demux.sv
// Randomized + directed bench for bus_demux; expectations come from a transaction-level model.
module tb_bus_demux;

  localparam int unsigned T    = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        t0_req_valid, t1_req_valid;
  logic        t0_req_ready = 1'b0, t1_req_ready = 1'b0;
  logic [31:0] t0_addr, t1_addr, t0_wdata, t1_wdata;
  logic        t0_we, t1_we;
  logic [3:0]  t0_be, t1_be;
  logic        t0_rsp_valid = 1'b0, t1_rsp_valid = 1'b0;
  logic [31:0] t0_rsp_rdata = '0, t1_rsp_rdata = '0;
  logic        err_spurious;

  int checks = 0;
  int errors = 0;
  logic exp_spur = 1'b0;

  always #5 clk = ~clk;

  bus_demux #(
    .DW(32), .AW(32), .MMIO_BASE(BASE), .TIMEOUT(T), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .t0_req_valid(t0_req_valid), .t0_req_ready(t0_req_ready), .t0_addr(t0_addr),
    .t0_we(t0_we), .t0_be(t0_be), .t0_wdata(t0_wdata),
    .t0_rsp_valid(t0_rsp_valid), .t0_rsp_rdata(t0_rsp_rdata),
    .t1_req_valid(t1_req_valid), .t1_req_ready(t1_req_ready), .t1_addr(t1_addr),
    .t1_we(t1_we), .t1_be(t1_be), .t1_wdata(t1_wdata),
    .t1_rsp_valid(t1_rsp_valid), .t1_rsp_rdata(t1_rsp_rdata),
    .err_spurious(err_spurious)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_t0_valid"}, 32'(t0_req_valid), 32'd0);
    chk({tag, "_t1_valid"}, 32'(t1_req_valid), 32'd0);
    chk({tag, "_t0_addr"}, t0_addr, 32'd0);
    chk({tag, "_t1_wdata"}, t1_wdata, 32'd0);
    chk({tag, "_spurious"}, 32'(err_spurious), 32'd0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    req_valid = 1'b0;
    t0_req_ready = 1'b0; t1_req_ready = 1'b0;
    t0_rsp_valid = 1'b0; t1_rsp_valid = 1'b0;
    #1;
    exp_spur = 1'b0;
    check_idle_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_no_rsp"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  // One initiator transaction. Called and returns at a negedge; on return the DUT
  // is in IDLE showing the completion, so the next call is back-to-back.
  // rdly: cycles target holds off req_ready; d: response sampled d edges after
  // the req handshake edge (d > T means the target never answers).
  task automatic txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                     input logic [31:0] wd, input int rdly, input int d,
                     input logic [31:0] rd, input bit spur_other);
    logic s;
    bit   tmo;
    int   lat;
    s   = (a >= BASE);
    tmo = (d > int'(T));
    lat = tmo ? int'(T) : d;

    chk("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a; req_we = we; req_be = be; req_wdata = wd;
    @(negedge clk);
    // Initiator noise after the handshake must be ignored.
    req_valid = 1'($urandom_range(0, 1));
    req_addr = $urandom; req_we = 1'($urandom); req_be = 4'($urandom); req_wdata = $urandom;

    chk("busy_ready", 32'(req_ready), 32'd0);
    chk("sel_valid", 32'(s ? t1_req_valid : t0_req_valid), 32'd1);
    chk("unsel_valid", 32'(s ? t0_req_valid : t1_req_valid), 32'd0);
    chk("t_addr", s ? t1_addr : t0_addr, a);
    chk("t_we", 32'(s ? t1_we : t0_we), 32'(we));
    chk("t_be", 32'(s ? t1_be : t0_be), 32'(be));
    chk("t_wdata", s ? t1_wdata : t0_wdata, wd);
    chk("mirror_addr", s ? t0_addr : t1_addr, a);

    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(s ? t1_req_valid : t0_req_valid), 32'd1);
      chk("hold_unsel", 32'(s ? t0_req_valid : t1_req_valid), 32'd0);
      chk("hold_addr", s ? t1_addr : t0_addr, a);
    end
    if (s) t1_req_ready = 1'b1; else t0_req_ready = 1'b1;
    @(negedge clk);
    t0_req_ready = 1'b0; t1_req_ready = 1'b0;
    chk("valid_drop", 32'(s ? t1_req_valid : t0_req_valid), 32'd0);

    for (int j = 0; j <= lat; j++) begin
      if (j > 0) @(negedge clk);
      chk("rsp_timing", 32'(rsp_valid), 32'(j == lat));
      t0_rsp_valid = 1'b0; t1_rsp_valid = 1'b0;
      t0_rsp_rdata = $urandom; t1_rsp_rdata = $urandom;
      if (!tmo && (j == d - 1)) begin
        if (s) begin t1_rsp_valid = 1'b1; t1_rsp_rdata = rd; end
        else   begin t0_rsp_valid = 1'b1; t0_rsp_rdata = rd; end
      end
      if (spur_other && (j == 0)) begin
        if (s) t0_rsp_valid = 1'b1; else t1_rsp_valid = 1'b1;
        exp_spur = 1'b1;
      end
    end
    req_valid = 1'b0;
    chk("rsp_err", 32'(rsp_err), 32'(tmo));
    chk("rsp_rdata", rsp_rdata, tmo ? ERRD : (we ? 32'd0 : rd));
    chk("done_ready", 32'(req_ready), 32'd1);
    chk("spurious", 32'(err_spurious), 32'(exp_spur));
  endtask

  initial begin
    logic [31:0] a;
    int          pick;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Port-0 load with delayed ready and response.
    txn(32'h0000_0040, 1'b0, 4'hF, 32'h0, 2, 4, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("pulse_one_cycle", 32'(rsp_valid), 32'd0);

    // MMIO store, immediate ready; address boundaries.
    txn(32'hFFFF_0000, 1'b1, 4'b0011, 32'hA5A5_A5A5, 0, 2, 32'h5555_AAAA, 1'b0);
    txn(32'hFFFE_FFFF, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0BAD_F00D, 1'b0);
    txn(32'hFFFF_FFFF, 1'b0, 4'hF, 32'h0, 1, 3, 32'hCAFE_0001, 1'b0);

    // Back-to-back loads: second accepted on the first completion cycle.
    txn(32'h0000_1000, 1'b0, 4'hF, 32'h0, 0, 1, 32'h1111_1111, 1'b0);
    txn(32'h0000_2000, 1'b0, 4'hF, 32'h0, 0, 2, 32'h2222_2222, 1'b0);
    @(negedge clk);

    // Reset in REQ.
    req_valid = 1'b1; req_addr = 32'h0000_0100; req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_reset_req", 32'(t0_req_valid), 32'd1);
    pulse_reset("rst_req");
    txn(32'h0000_0200, 1'b0, 4'hF, 32'h0, 0, 2, 32'h3333_3333, 1'b0);

    // Reset in WAIT_RSP.
    req_valid = 1'b1; req_addr = 32'hFFFF_1234; req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; t1_req_ready = 1'b1;
    @(negedge clk);
    t1_req_ready = 1'b0;
    @(negedge clk);
    pulse_reset("rst_wait");
    txn(32'hFFFF_0010, 1'b0, 4'hF, 32'h0, 0, 1, 32'h4444_4444, 1'b0);

    // Spurious response while idle, then during a port-0 wait.
    t1_rsp_valid = 1'b1;
    @(negedge clk);
    t1_rsp_valid = 1'b0;
    exp_spur = 1'b1;
    chk("spur_idle", 32'(err_spurious), 32'd1);
    txn(32'h0000_0300, 1'b0, 4'hF, 32'h0, 1, 3, 32'h6666_7777, 1'b1);
    @(negedge clk);

    // Watchdog: t0 never answers, late answer is spurious.
    pulse_reset("rst_tmo");
    txn(32'h0000_0400, 1'b0, 4'hF, 32'h0, 0, 1000, 32'h0, 1'b0);
    t0_rsp_valid = 1'b1;
    @(negedge clk);
    t0_rsp_valid = 1'b0;
    exp_spur = 1'b1;
    chk("late_rsp_spur", 32'(err_spurious), 32'd1);
    chk("late_rsp_ignored", 32'(rsp_valid), 32'd0);

    // Response coinciding with the watchdog edge wins.
    pulse_reset("rst_rand");
    txn(32'h0000_0500, 1'b0, 4'hF, 32'h0, 0, int'(T), 32'h7777_8888, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      pick = int'($urandom_range(0, 5));
      case (pick)
        0: a = BASE - 32'd1;
        1: a = BASE;
        2: a = 32'hFFFF_FFFF;
        3: a = BASE + 32'($urandom_range(0, 32'h0000_FFFF));
        default: a = $urandom;
      endcase
      txn(a, 1'($urandom), 4'($urandom), $urandom, int'($urandom_range(0, 3)),
          (($urandom_range(0, 7) == 0) ? int'(T) + 1 : int'($urandom_range(1, T))),
          $urandom, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
